dsp_post_adder: RTL and testbench

Post-adder/subtractor stage of the DSP slice. Consumes the 48-bit Y multiplexer output and the 48-bit X multiplexer output. Computes `Y ± (X + CIN)` with a selectable carry-in source. Drives the registered P result, the P cascade output and the carry-out. Optional pipeline registers on the opmode, carry-in, P and carry-out paths, each with its own clock enable.

---
 rtl/dsp_post_adder.sv | 129 ++++++++++++
 tb/tb_dsp_post_adder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dsp_post_adder.sv
// dsp_post_adder -- post-adder/subtractor stage of the DSP slice.
//
// Computes P = Y +/- (X + cin) at 49 bits. Bit 48 is the carry on an add and
// the borrow on a subtract. Each of the opmode, carry-in, P and carry-out
// paths can be registered or combinational.
//
// Parameters:
//   OPMODEREG   - 1: OPMODE[7]/OPMODE[5] pass through OPMODE_R (CE = CEOPMODE)
//   CARRYINREG  - 1: selected carry-in passes through CIN_R (CE = CECARRYIN)
//   PREG        - 1: P registered (CE = CEP)
//   CARRYOUTREG - 1: carry-out registered (CE = CEP)
//   CARRYINSEL  - "CARRYIN" selects the CARRYIN port; any other value selects OPMODE[5]
//
// Ports:
//   CLK, RST_N            - rising-edge clock, async active-low reset
//   CEOPMODE, CECARRYIN   - register clock enables
//   CEP                   - clock enable for the P and carry-out registers
//   OPMODE[7:0]           - bit 7 = subtract, bit 5 = carry-in value
//   CARRYIN               - external carry-in
//   X_MUX_OUT, Y_MUX_OUT  - 48-bit operands
//   P, PCOUT              - result and its cascade copy
//   CARRYOUT, CARRYOUTF   - carry/borrow out of bit 47 and its fabric copy
//   OVERFLOW              - signed overflow, only when POSTADD_OVERFLOW_EN is defined
//
// Optional feature macro: POSTADD_OVERFLOW_EN
module dsp_post_adder #(
  parameter int    OPMODEREG   = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYOUTREG = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CEOPMODE,
  input  logic        CECARRYIN,
  input  logic        CEP,
  input  logic [7:0]  OPMODE,
  input  logic        CARRYIN,
  input  logic [47:0] X_MUX_OUT,
  input  logic [47:0] Y_MUX_OUT,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
`ifdef POSTADD_OVERFLOW_EN
  ,
  output logic        OVERFLOW
`endif
);

  localparam bit USE_CARRYIN = (CARRYINSEL == "CARRYIN");

  // opmode_q = {subtract, carry-in value}
  logic [1:0]  opmode_q, opmode_d;
  logic        cin_q, cin_d;
  logic [47:0] p_q, p_d;
  logic        co_q, co_d;

  logic        sub_eff, op5_eff, cin_sel, cin_eff;
  logic [48:0] addend, sum;

  // Only bits 7 and 5 of OPMODE matter to this stage.
  logic        unused_opmode;
  assign unused_opmode = ^{OPMODE[6], OPMODE[4:0]};

`ifdef POSTADD_OVERFLOW_EN
  logic ov_q, ov_d;
  logic ov_next;
`endif

  always_comb begin
    sub_eff = (OPMODEREG != 0) ? opmode_q[1] : OPMODE[7];
    op5_eff = (OPMODEREG != 0) ? opmode_q[0] : OPMODE[5];
    cin_sel = USE_CARRYIN ? CARRYIN : op5_eff;
    cin_eff = (CARRYINREG != 0) ? cin_q : cin_sel;

    // X + cin is formed first so that subtract borrows across the whole
    // 49-bit addend, X = all-ones with cin = 1 included.
    addend = {1'b0, X_MUX_OUT} + {48'd0, cin_eff};
    sum    = sub_eff ? ({1'b0, Y_MUX_OUT} - addend)
                     : ({1'b0, Y_MUX_OUT} + addend);

    opmode_d = CEOPMODE  ? {OPMODE[7], OPMODE[5]} : opmode_q;
    cin_d    = CECARRYIN ? cin_sel                : cin_q;
    p_d      = CEP       ? sum[47:0]              : p_q;
    co_d     = CEP       ? sum[48]                : co_q;

`ifdef POSTADD_OVERFLOW_EN
    // Sign test uses the raw operands; carry-in only reaches P.
    if (sub_eff)
      ov_next = (Y_MUX_OUT[47] != X_MUX_OUT[47]) && (sum[47] != Y_MUX_OUT[47]);
    else
      ov_next = (Y_MUX_OUT[47] == X_MUX_OUT[47]) && (sum[47] != Y_MUX_OUT[47]);
    ov_d = CEP ? ov_next : ov_q;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      opmode_q <= '0;
      cin_q    <= 1'b0;
      p_q      <= '0;
      co_q     <= 1'b0;
`ifdef POSTADD_OVERFLOW_EN
      ov_q     <= 1'b0;
`endif
    end else begin
      opmode_q <= opmode_d;
      cin_q    <= cin_d;
      p_q      <= p_d;
      co_q     <= co_d;
`ifdef POSTADD_OVERFLOW_EN
      ov_q     <= ov_d;
`endif
    end
  end

  always_comb begin
    P         = (PREG != 0) ? p_q : sum[47:0];
    PCOUT     = P;
    CARRYOUT  = (CARRYOUTREG != 0) ? co_q : sum[48];
    CARRYOUTF = CARRYOUT;
`ifdef POSTADD_OVERFLOW_EN
    OVERFLOW  = (PREG != 0) ? ov_q : ov_next;
`endif
  end

endmodule

// File: tb/tb_dsp_post_adder.sv
module tb_dsp_post_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ceopmode, cecarryin, cep;
  logic [7:0]  opmode;
  logic        carryin;
  logic [47:0] x, y;

  logic [47:0] p_reg, pc_reg, p_comb, pc_comb, p_cin, pc_cin;
  logic        co_reg, cof_reg, co_comb, cof_comb, co_cin, cof_cin;
`ifdef POSTADD_OVERFLOW_EN
  logic        ov_reg, ov_comb, ov_cin;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Fully registered, carry-in from OPMODE[5]
  dsp_post_adder #(
    .OPMODEREG(1), .CARRYINREG(1), .PREG(1), .CARRYOUTREG(1), .CARRYINSEL("OPMODE5")
  ) u_reg (
    .CLK(clk), .RST_N(rst_n), .CEOPMODE(ceopmode), .CECARRYIN(cecarryin), .CEP(cep),
    .OPMODE(opmode), .CARRYIN(carryin), .X_MUX_OUT(x), .Y_MUX_OUT(y),
    .P(p_reg), .PCOUT(pc_reg), .CARRYOUT(co_reg), .CARRYOUTF(cof_reg)
`ifdef POSTADD_OVERFLOW_EN
    , .OVERFLOW(ov_reg)
`endif
  );

  // Fully combinational
  dsp_post_adder #(
    .OPMODEREG(0), .CARRYINREG(0), .PREG(0), .CARRYOUTREG(0), .CARRYINSEL("OPMODE5")
  ) u_comb (
    .CLK(clk), .RST_N(rst_n), .CEOPMODE(ceopmode), .CECARRYIN(cecarryin), .CEP(cep),
    .OPMODE(opmode), .CARRYIN(carryin), .X_MUX_OUT(x), .Y_MUX_OUT(y),
    .P(p_comb), .PCOUT(pc_comb), .CARRYOUT(co_comb), .CARRYOUTF(cof_comb)
`ifdef POSTADD_OVERFLOW_EN
    , .OVERFLOW(ov_comb)
`endif
  );

  // Fully registered, carry-in from the CARRYIN port
  dsp_post_adder #(
    .OPMODEREG(1), .CARRYINREG(1), .PREG(1), .CARRYOUTREG(1), .CARRYINSEL("CARRYIN")
  ) u_cin (
    .CLK(clk), .RST_N(rst_n), .CEOPMODE(ceopmode), .CECARRYIN(cecarryin), .CEP(cep),
    .OPMODE(opmode), .CARRYIN(carryin), .X_MUX_OUT(x), .Y_MUX_OUT(y),
    .P(p_cin), .PCOUT(pc_cin), .CARRYOUT(co_cin), .CARRYOUTF(cof_cin)
`ifdef POSTADD_OVERFLOW_EN
    , .OVERFLOW(ov_cin)
`endif
  );

  task automatic chk(input string tag, input logic [48:0] obs, input logic [48:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; ceopmode = 1'b1; cecarryin = 1'b1; cep = 1'b1;
    opmode = 8'h00; carryin = 1'b0; x = '0; y = '0;

    #1;
    chk("reset_p",  {1'b0, p_reg},  49'd0);
    chk("reset_co", {48'd0, co_reg}, 49'd0);
    step(2);
    rst_n = 1'b1;

    // Add wrap
    y = 48'hFFFF_FFFF_FFFF; x = 48'd1; opmode = 8'h00;
    #1;
    chk("wrap_comb", {co_comb, p_comb}, {1'b1, 48'd0});
    step(2);
    chk("wrap_reg",  {co_reg, p_reg},   {1'b1, 48'd0});
    chk("wrap_copy", {cof_reg, pc_reg}, {1'b1, 48'd0});

    // Subtract with carry-in from OPMODE[5]
    opmode = 8'hA0; y = 48'd100; x = 48'd30;
    #1;
    chk("sub_cin_comb", {co_comb, p_comb}, {1'b0, 48'd69});
    step(3);
    chk("sub_cin_reg",  {co_reg, p_reg},   {1'b0, 48'd69});
    y = 48'd5; x = 48'd10;
    #1;
    chk("sub_neg_comb", {co_comb, p_comb}, {1'b1, 48'hFFFF_FFFF_FFFA});
    step(1);
    chk("sub_neg_reg",  {co_reg, p_reg},   {1'b1, 48'hFFFF_FFFF_FFFA});
    chk("sub_neg_copy", {cof_reg, pc_reg}, {1'b1, 48'hFFFF_FFFF_FFFA});

    // OPMODE latency: registered = 2 edges, combinational = immediate
    opmode = 8'h00; y = 48'd100; x = 48'd30;
    step(3);
    chk("lat_base", {co_reg, p_reg}, {1'b0, 48'd130});
    opmode = 8'h80;
    #1;
    chk("lat_comb_now", {co_comb, p_comb}, {1'b0, 48'd70});
    chk("lat_reg_now",  {co_reg, p_reg},   {1'b0, 48'd130});
    step(1);
    chk("lat_reg_e1",   {co_reg, p_reg},   {1'b0, 48'd130});
    step(1);
    chk("lat_reg_e2",   {co_reg, p_reg},   {1'b0, 48'd70});

    // CE hold
    opmode = 8'h00; y = 48'd7; x = 48'd0;
    step(2);
    chk("ce_load", {co_reg, p_reg}, {1'b0, 48'd7});
    cep = 1'b0; y = 48'hFFFF_FFFF_FFFF; x = 48'd5;
    for (int unsigned i = 0; i < 3; i++) begin
      step(1);
      chk("ce_hold", {co_reg, p_reg}, {1'b0, 48'd7});
      y = y - 48'd1;
    end
    y = 48'hFFFF_FFFF_FFFF;
    cep = 1'b1;
    step(1);
    chk("ce_resume", {co_reg, p_reg}, {1'b1, 48'd4});

    // Asynchronous reset mid-stream
    y = 48'h123; x = 48'd0;
    step(2);
    chk("rst_pre", {co_reg, p_reg}, {1'b0, 48'h123});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async",   {co_reg, p_reg},   49'd0);
    chk("rst_async_c", {cof_reg, pc_reg}, 49'd0);
    step(2);
    chk("rst_hold",    {co_reg, p_reg},   49'd0);
    rst_n = 1'b1;
    step(1);
    chk("rst_release", {co_reg, p_reg},   {1'b0, 48'h123});

    // CARRYIN port path
    y = 48'd0; x = 48'd0; opmode = 8'h00; carryin = 1'b0;
    step(2);
    chk("cin_base", {co_cin, p_cin}, 49'd0);
    carryin = 1'b1;
    step(1);
    chk("cin_e1",   {co_cin, p_cin}, 49'd0);
    step(1);
    chk("cin_e2",   {co_cin, p_cin}, {1'b0, 48'd1});
    chk("cin_copy", {cof_cin, pc_cin}, {1'b0, 48'd1});
    chk("cin_ignored_by_op5", {co_reg, p_reg}, 49'd0);

`ifdef POSTADD_OVERFLOW_EN
    carryin = 1'b0;
    y = 48'h7FFF_FFFF_FFFF; x = 48'd1; opmode = 8'h00;
    #1;
    chk("ovf_comb", {48'd0, ov_comb}, 49'd1);
    step(2);
    chk("ovf_reg",  {48'd0, ov_reg},  49'd1);
    y = 48'd5; x = 48'd3;
    step(2);
    chk("ovf_none", {48'd0, ov_reg},  49'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
